// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN classifier readout.
// Score format is signed Q8.8.
package bnn_pkg;

   localparam int SCORE_W = 16;
   localparam logic signed [SCORE_W-1:0] SCORE_MIN = 16'sh8000;

   typedef logic signed [SCORE_W-1:0] score_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DONE  = 2'd2,
      REARM = 2'd3
   } argmax_state_t;

endpackage

// File: rtl/argmax_update.sv
// One step of the running top-1/top-2 search.
// Strict compares keep the lower index on ties.
module argmax_update
   import bnn_pkg::*;
#(
   parameter int W  = SCORE_W,
   parameter int IW = 4
) (
   input  logic                first,
   input  logic signed [W-1:0] best,
   input  logic signed [W-1:0] second,
   input  logic [IW-1:0]       best_idx,
   input  logic signed [W-1:0] s,
   input  logic [IW-1:0]       idx,
   output logic signed [W-1:0] best_n,
   output logic signed [W-1:0] second_n,
   output logic [IW-1:0]       best_idx_n
);

   localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

   // fold score s into the running best/second pair
   always_comb begin
      best_n     = best;
      second_n   = second;
      best_idx_n = best_idx;
      if (first) begin
         best_n     = s;
         second_n   = SMIN;
         best_idx_n = '0;
      end else if (s > best) begin
         second_n   = best;
         best_n     = s;
         best_idx_n = idx;
      end else if (s > second) begin
         second_n   = s;
      end
   end

endmodule

// File: rtl/fc_argmax.sv
// Classifier readout: scans FC scores, reports argmax,
// best score and top-1/top-2 margin with valid/ack hold.
module fc_argmax
   import bnn_pkg::*;
#(
   parameter int OC = 10,
   parameter int W  = SCORE_W,
   localparam int IW = (OC > 1) ? $clog2(OC) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                scores_ready,
   input  logic signed [W-1:0] scores [0:OC-1],
   output logic                result_valid,
   input  logic                result_ack,
   output logic [IW-1:0]       class_idx,
   output logic signed [W-1:0] best_score,
   output logic [W:0]          margin
);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_SCAN  = SCAN;
   localparam logic [1:0] ST_DONE  = DONE;
   localparam logic [1:0] ST_REARM = REARM;

   localparam logic [IW-1:0] LAST = IW'(OC - 1);

   logic [1:0]          state;
   logic [IW-1:0]       idx;
   logic signed [W-1:0] best;
   logic signed [W-1:0] second;
   logic [IW-1:0]       best_idx;

   logic signed [W-1:0] best_n;
   logic signed [W-1:0] second_n;
   logic [IW-1:0]       best_idx_n;
   logic [W:0]          margin_n;

   argmax_update #(
      .W  (W),
      .IW (IW)
   ) u_update (
      .first      (idx == '0),
      .best       (best),
      .second     (second),
      .best_idx   (best_idx),
      .s          (scores[idx]),
      .idx        (idx),
      .best_n     (best_n),
      .second_n   (second_n),
      .best_idx_n (best_idx_n)
   );

   // margin from the final pair; best >= second so never negative
   assign margin_n = {best_n[W-1], best_n} - {second_n[W-1], second_n};

   // FSM, scan index, running state and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         idx          <= '0;
         best         <= '0;
         second       <= '0;
         best_idx     <= '0;
         result_valid <= 1'b0;
         class_idx    <= '0;
         best_score   <= '0;
         margin       <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (scores_ready) begin
                  state <= ST_SCAN;
                  idx   <= '0;
               end
            end
            ST_SCAN: begin
               if (!scores_ready) begin
                  state <= ST_IDLE;
               end else begin
                  best     <= best_n;
                  second   <= second_n;
                  best_idx <= best_idx_n;
                  if (idx == LAST) begin
                     class_idx    <= best_idx_n;
                     best_score   <= best_n;
                     margin       <= margin_n;
                     result_valid <= 1'b1;
                     state        <= ST_DONE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (result_ack) begin
                  result_valid <= 1'b0;
                  state <= scores_ready ? ST_REARM : ST_IDLE;
               end
            end
            ST_REARM: begin
               if (!scores_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax (OC=10, Q8.8 scores).
// Expected values are hand-computed constants.
module tb_fc_argmax;

   localparam int OC = 10;
   localparam int W  = 16;

   logic               clk;
   logic               rst;
   logic               scores_ready;
   logic signed [15:0] scores [0:OC-1];
   logic               result_valid;
   logic               result_ack;
   logic [3:0]         class_idx;
   logic signed [15:0] best_score;
   logic [16:0]        margin;

   int checks = 0;
   int errors = 0;

   fc_argmax #(.OC(OC), .W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .scores_ready (scores_ready),
      .scores       (scores),
      .result_valid (result_valid),
      .result_ack   (result_ack),
      .class_idx    (class_idx),
      .best_score   (best_score),
      .margin       (margin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag,
                            input logic [3:0]  ec,
                            input logic [15:0] eb,
                            input logic [16:0] em);
      check({tag, "_class"}, 64'(class_idx), 64'(ec));
      check({tag, "_best"}, 64'($unsigned(best_score)), 64'(eb));
      check({tag, "_margin"}, 64'(margin), 64'(em));
   endtask

   // raise ready, expect valid exactly OC edges after the sampling edge
   task automatic run_scan(input string tag,
                           input logic [3:0]  ec,
                           input logic [15:0] eb,
                           input logic [16:0] em);
      scores_ready = 1'b1;
      step();
      for (int i = 0; i < OC - 1; i++) begin
         step();
         check({tag, "_early"}, 64'(result_valid), 64'd0);
      end
      step();
      check({tag, "_valid"}, 64'(result_valid), 64'd1);
      check_out(tag, ec, eb, em);
   endtask

   task automatic ack_and_drop();
      result_ack = 1'b1;
      step();
      check("ack_clear", 64'(result_valid), 64'd0);
      result_ack   = 1'b0;
      scores_ready = 1'b0;
      step();
      step();
   endtask

   task automatic load_case1();
      for (int i = 0; i < OC; i++) scores[i] = 16'sh0100;
      scores[7] = 16'sh0500;
      scores[3] = 16'sh0300;
   endtask

   initial begin
      rst          = 1'b1;
      scores_ready = 1'b0;
      result_ack   = 1'b0;
      for (int i = 0; i < OC; i++) scores[i] = '0;
      step();
      step();
      check("rst_valid", 64'(result_valid), 64'd0);
      check_out("rst", 4'd0, 16'h0000, 17'h00000);
      rst = 1'b0;
      step();

      // 1: clear winner at 7, runner-up at 3
      load_case1();
      run_scan("c1", 4'd7, 16'h0500, 17'h00200);
      ack_and_drop();

      // 2: tie at top, lower index wins, margin 0
      for (int i = 0; i < OC; i++) scores[i] = 16'sh0000;
      scores[2] = 16'sh0400;
      scores[5] = 16'sh0400;
      run_scan("c2", 4'd2, 16'h0400, 17'h00000);
      ack_and_drop();

      // 3: all negative, descending
      for (int i = 0; i < OC; i++) scores[i] = 16'(-(i + 1) * 256);
      run_scan("c3", 4'd0, 16'hFF00, 17'h00100);
      ack_and_drop();

      // 4: full-range margin
      for (int i = 0; i < OC; i++) scores[i] = 16'sh8000;
      scores[9] = 16'sh7FFF;
      run_scan("c4", 4'd9, 16'h7FFF, 17'h0FFFF);
      ack_and_drop();

      // 5: abort at idx 4 keeps previous result, no valid
      load_case1();
      scores_ready = 1'b1;
      step();
      for (int i = 0; i < 4; i++) step();
      scores_ready = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         step();
         check("abort_valid", 64'(result_valid), 64'd0);
      end
      check_out("abort_hold", 4'd9, 16'h7FFF, 17'h0FFFF);
      run_scan("c5", 4'd7, 16'h0500, 17'h00200);
      ack_and_drop();

      // 5b: reset mid-scan clears everything
      scores_ready = 1'b1;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      check("rst_scan_valid", 64'(result_valid), 64'd0);
      check_out("rst_scan", 4'd0, 16'h0000, 17'h00000);
      rst          = 1'b0;
      scores_ready = 1'b0;
      step();

      // 6: hold without ack, ready drop in DONE keeps result
      for (int i = 0; i < OC; i++) scores[i] = 16'(-(i + 1) * 256);
      run_scan("c6", 4'd0, 16'hFF00, 17'h00100);
      for (int i = 0; i < 20; i++) begin
         if (i == 8) scores_ready = 1'b0;
         if (i == 14) scores_ready = 1'b1;
         step();
         check("hold_valid", 64'(result_valid), 64'd1);
         check_out("hold", 4'd0, 16'hFF00, 17'h00100);
      end
      result_ack = 1'b1;
      step();
      check("c6_ack", 64'(result_valid), 64'd0);
      result_ack = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         check("rearm_valid", 64'(result_valid), 64'd0);
      end
      check_out("rearm_hold", 4'd0, 16'hFF00, 17'h00100);
      scores_ready = 1'b0;
      step();
      load_case1();
      run_scan("c6b", 4'd7, 16'h0500, 17'h00200);
      ack_and_drop();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
